lsu_ram_master: RTL and testbench

Load/store initiator that drives the byte-lane single-port data RAM on behalf of the core's memory stage. Accepts one LDR/STR-class request at a time over a valid/ready handshake, checks size, alignment and range, and generates the RAM's size/address/write-enable/write-data. Captures the RAM's registered read data and returns it zero- or sign-extended over a valid/ready response channel. Sits between the execute/memory pipeline stage and the data RAM.

---
 rtl/lsu_ram_master.sv | 90 +++++++++
 tb/tb_lsu_ram_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_master.sv
// lsu_ram_master: load/store initiator for the byte-lane data RAM (define LSU_ALIGN_CHECK_EN to fault misaligned accesses)
module lsu_ram_master #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        ram_size,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic fault_q, write_q, signed_q;
  logic range_bad, fault;
  logic [ADDR_W-1:0] addr_al;
  logic [31:0] repl, ext;
  assign range_bad = |req_addr[31:ADDR_W];
`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && |req_addr[1:0]);
  assign fault = req_size == 2'b11 || range_bad || misaligned;
  assign addr_al = req_addr[ADDR_W-1:0];
`else
  logic [1:0] low_mask;
  assign low_mask = req_size == 2'b01 ? 2'b01 : req_size == 2'b10 ? 2'b11 : 2'b00;
  assign fault = req_size == 2'b11 || range_bad;
  assign addr_al = req_addr[ADDR_W-1:0] & ~{{(ADDR_W-2){1'b0}}, low_mask};
`endif
  assign repl = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign ext = ram_size == 2'b00 ? {{24{signed_q & ram_rdata[7]}}, ram_rdata[7:0]} :
               ram_size == 2'b01 ? {{16{signed_q & ram_rdata[15]}}, ram_rdata[15:0]} : ram_rdata;
  // request/access/response sequencer with all RAM and response outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      ram_we    <= 1'b0;
      ram_size  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      fault_q   <= 1'b0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state     <= ACCESS;
          req_ready <= 1'b0;
          ram_addr  <= addr_al;
          ram_size  <= req_size;
          ram_we    <= req_write && !fault;
          ram_wdata <= repl;
          fault_q   <= fault;
          write_q   <= req_write;
          signed_q  <= req_signed;
        end
        ACCESS: begin
          state     <= RESP;
          ram_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_fault <= fault_q;
          rsp_rdata <= (fault_q || write_q) ? 32'd0 : ext;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ram_master.sv
// tb_lsu_ram_master: directed checks of lsu_ram_master against a byte-lane RAM model
module tb_lsu_ram_master;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_fault, ram_we;
  logic [31:0] rsp_rdata, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [1:0] ram_size;
  logic [9:0] ram_addr;
  logic [7:0] mem [0:1023];
  int n_cmp = 0, n_err = 0;
  logic [31:0] held;

  lsu_ram_master #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .ram_size(ram_size), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: lane-selected byte writes on rising edge, little-endian read on falling edge
  always @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++) begin
        logic [9:0] a;
        a = ram_addr + 10'(i);
        if (i < (ram_size == 2'b00 ? 1 : ram_size == 2'b01 ? 2 : 4))
          mem[a] <= ram_wdata[8*a[1:0] +: 8];
      end
  end

  always @(negedge clk)
    ram_rdata <= {mem[ram_addr + 10'd3], mem[ram_addr + 10'd2], mem[ram_addr + 10'd1], mem[ram_addr]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // present one request, returning #1 after the accept edge (unit in ACCESS)
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // step into RESP, check response, let it retire with rsp_ready high
  task automatic finish_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_fault);
    tick();
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_fault"}, {31'd0, rsp_fault}, {31'd0, exp_fault});
    chk({tag, "_we_off"}, {31'd0, ram_we}, 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    tick();
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_size", {30'd0, ram_size}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    tick();

    issue(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
    chk("sw_we", {31'd0, ram_we}, 32'd1);
    chk("sw_addr", {22'd0, ram_addr}, 32'h010);
    chk("sw_size", {30'd0, ram_size}, 32'd2);
    chk("sw_wdata", ram_wdata, 32'hDEADBEEF);
    chk("sw_rsp_early", {31'd0, rsp_valid}, 32'd0);
    chk("sw_req_ready_low", {31'd0, req_ready}, 32'd0);
    finish_rsp("sw", 32'd0, 1'b0);
    chk("sw_req_ready_back", {31'd0, req_ready}, 32'd1);

    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    chk("lw_we", {31'd0, ram_we}, 32'd0);
    finish_rsp("lw", 32'hDEADBEEF, 1'b0);

    issue(1'b1, 2'b00, 1'b0, 32'h013, 32'h12345680);
    chk("sb_we", {31'd0, ram_we}, 32'd1);
    chk("sb_wdata", ram_wdata, 32'h80808080);
    finish_rsp("sb", 32'd0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h013, 32'h0);
    finish_rsp("lsb", 32'hFFFFFF80, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h013, 32'h0);
    finish_rsp("lub", 32'h00000080, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    finish_rsp("lw2", 32'h80ADBEEF, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h012, 32'h0);
    finish_rsp("lsh", 32'hFFFF80AD, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h012, 32'h0);
    finish_rsp("luh", 32'h000080AD, 1'b0);

    issue(1'b1, 2'b01, 1'b0, 32'h011, 32'h00001234);
`ifdef LSU_ALIGN_CHECK_EN
    chk("sh_mis_we", {31'd0, ram_we}, 32'd0);
    finish_rsp("sh_mis", 32'd0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    finish_rsp("lw3", 32'h80ADBEEF, 1'b0);
`else
    chk("sh_mis_we", {31'd0, ram_we}, 32'd1);
    chk("sh_mis_addr", {22'd0, ram_addr}, 32'h010);
    chk("sh_mis_wdata", ram_wdata, 32'h12341234);
    finish_rsp("sh_mis", 32'd0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    finish_rsp("lw3", 32'h80AD1234, 1'b0);
`endif

    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    chk("range_we", {31'd0, ram_we}, 32'd0);
    finish_rsp("range", 32'd0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h020, 32'hFFFFFFFF);
    chk("sz11_we", {31'd0, ram_we}, 32'd0);
    finish_rsp("sz11", 32'd0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
    finish_rsp("sz11_nowrite", 32'd0, 1'b0);

    issue(1'b1, 2'b10, 1'b0, 32'h030, 32'hCAFEF00D);
    finish_rsp("s_cafe", 32'd0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h030, 32'h0);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h040; req_wdata = 32'h11111111;
    tick();
    held = rsp_rdata;
    chk("stall_rdata0", rsp_rdata, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, held);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_we", {31'd0, ram_we}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("retire_valid", {31'd0, rsp_valid}, 32'd0);
    chk("retire_req_ready", {31'd0, req_ready}, 32'd1);
    chk("retire_no_accept", {31'd0, ram_we}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("pend_we", {31'd0, ram_we}, 32'd1);
    chk("pend_wdata", ram_wdata, 32'h11111111);
    finish_rsp("pend", 32'd0, 1'b0);

    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstld_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstld_req_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b1, 2'b10, 1'b0, 32'h020, 32'h55AA55AA);
    chk("rstst_we", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstst_we_off", {31'd0, ram_we}, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
    finish_rsp("rstst_load", 32'h55AA55AA, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
